// File: rtl/ramp_pkg.sv
// Shared definitions for the ramp sequencer and the per-channel DAC ramp blocks:
// sequencer state encoding and the signed state codes reported by each ramp block.
package ramp_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ARMED     = 3'd1,
        RAMP_UP   = 3'd2,
        RUNNING   = 3'd3,
        RAMP_DOWN = 3'd4,
        DONE      = 3'd5,
        FAULT     = 3'd6
    } seq_state_t;

    localparam int CODE_W = 16;

    localparam logic signed [CODE_W-1:0] CODE_UP      =  16'sd2000;
    localparam logic signed [CODE_W-1:0] CODE_NORMAL  =  16'sd0;
    localparam logic signed [CODE_W-1:0] CODE_REQDOWN = -16'sd2000;
    localparam logic signed [CODE_W-1:0] CODE_DOWN    = -16'sd4000;
    localparam logic signed [CODE_W-1:0] CODE_DONE    =  16'sd4000;

    // Ramp blocks are out of reset and enabled only in these states.
    function automatic logic is_active(input seq_state_t s);
        return (s == RAMP_UP) || (s == RUNNING) || (s == RAMP_DOWN);
    endfunction

    function automatic logic is_busy(input seq_state_t s);
        return (s == ARMED) || is_active(s);
    endfunction

endpackage

// File: rtl/ramp_state_monitor.sv
// Reduces the per-channel ramp-state codes of the masked channels to two
// predicates: every masked channel is at NORMAL, every masked channel is DONE.
module ramp_state_monitor
    import ramp_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic [CODE_W*NUM_CH-1:0] ramp_state,
    input  logic [NUM_CH-1:0]        mask,
    output logic                     all_normal,
    output logic                     all_done
);

    // Unmasked channels never pull a predicate low, so an empty mask yields true.
    always_comb begin
        all_normal = 1'b1;
        all_done   = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            all_normal = all_normal & (~mask[i] | (ramp_state[CODE_W*i +: CODE_W] == CODE_NORMAL));
            all_done   = all_done   & (~mask[i] | (ramp_state[CODE_W*i +: CODE_W] == CODE_DONE));
        end
    end

endmodule

// File: rtl/ramp_sequencer.sv
// Run sequencer for a bank of DAC ramp blocks: arm, trigger, ramp up, run,
// ramp down, done, with a per-phase timeout that parks the bank in FAULT.
module ramp_sequencer
    import ramp_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int TO_W   = 32
) (
    input  logic                     clk,
    input  logic                     aresetn,
    input  logic [NUM_CH-1:0]        cfg_ch_mask,
    input  logic [TO_W-1:0]          cfg_timeout,
    input  logic                     cmd_start,
    input  logic                     cmd_stop,
    input  logic                     trigger,
    input  logic [CODE_W*NUM_CH-1:0] ramp_state,
    output logic                     ramper_resetn,
    output logic [NUM_CH-1:0]        enable_ramping,
    output logic [NUM_CH-1:0]        start_ramp_down,
    output logic                     busy,
    output logic                     done,
    output logic                     timeout_err,
    output logic [2:0]               seq_state
);

    localparam logic [TO_W-1:0]   TO_ZERO = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]   TO_ONE  = {{(TO_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]   TO_MAX  = {TO_W{1'b1}};
    localparam logic [NUM_CH-1:0] CH_ZERO = {NUM_CH{1'b0}};

    seq_state_t        state_r;
    logic [NUM_CH-1:0] mask_r;
    logic [TO_W-1:0]   to_r;
    logic [TO_W-1:0]   cnt_r;
    logic              stop_pending_r;
    logic              trig_d_r;

    logic trig_rise_s;
    logic start_ok_s;
    logic timeout_hit_s;
    logic all_normal_s;
    logic all_done_s;

    ramp_state_monitor #(
        .NUM_CH(NUM_CH)
    ) u_monitor (
        .ramp_state(ramp_state),
        .mask      (mask_r),
        .all_normal(all_normal_s),
        .all_done  (all_done_s)
    );

    assign trig_rise_s   = trigger & ~trig_d_r;
    // A simultaneous stop cancels a start wherever start would be accepted.
    assign start_ok_s    = cmd_start & ~cmd_stop;
    assign timeout_hit_s = (to_r != TO_ZERO) && (cnt_r == (to_r - TO_ONE));

    // Trigger history for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            trig_d_r <= 1'b0;
        end else begin
            trig_d_r <= trigger;
        end
    end

    // Phase timer: counts while ramping, saturates, and is zero in every other state.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            cnt_r <= TO_ZERO;
        end else if ((state_r == RAMP_UP) || (state_r == RAMP_DOWN)) begin
            if (cnt_r != TO_MAX) begin
                cnt_r <= cnt_r + TO_ONE;
            end
        end else begin
            cnt_r <= TO_ZERO;
        end
    end

    // Sequencer state plus outputs registered from the current state.
    always_ff @(posedge clk) begin
        if (!aresetn) begin
            state_r         <= IDLE;
            mask_r          <= CH_ZERO;
            to_r            <= TO_ZERO;
            stop_pending_r  <= 1'b0;
            ramper_resetn   <= 1'b0;
            enable_ramping  <= CH_ZERO;
            start_ramp_down <= CH_ZERO;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_err     <= 1'b0;
            seq_state       <= IDLE;
        end else begin
            ramper_resetn   <= is_active(state_r);
            enable_ramping  <= is_active(state_r) ? mask_r : CH_ZERO;
            start_ramp_down <= (state_r == RAMP_DOWN) ? mask_r : CH_ZERO;
            busy            <= is_busy(state_r);
            done            <= (state_r == DONE);
            seq_state       <= state_r;

            case (state_r)
                IDLE: begin
                    stop_pending_r <= 1'b0;
                    if (start_ok_s) begin
                        mask_r  <= cfg_ch_mask;
                        to_r    <= cfg_timeout;
                        state_r <= ARMED;
                    end
                end
                ARMED: begin
                    stop_pending_r <= 1'b0;
                    if (cmd_stop) begin
                        state_r <= IDLE;
                    end else if (trig_rise_s) begin
                        state_r <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    // A stop during ramp-up is deferred until the channels settle.
                    if (cmd_stop) begin
                        stop_pending_r <= 1'b1;
                    end
                    if (all_normal_s) begin
                        state_r <= RUNNING;
                    end else if (timeout_hit_s) begin
                        state_r <= FAULT;
                    end
                end
                RUNNING: begin
                    if (cmd_stop || stop_pending_r) begin
                        stop_pending_r <= 1'b0;
                        state_r        <= RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (all_done_s) begin
                        state_r <= DONE;
                    end else if (timeout_hit_s) begin
                        state_r <= FAULT;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                FAULT: begin
                    stop_pending_r <= 1'b0;
                    if (cmd_stop) begin
                        timeout_err <= 1'b1;
                        state_r     <= IDLE;
                    end else if (cmd_start) begin
                        timeout_err <= 1'b0;
                        mask_r      <= cfg_ch_mask;
                        to_r        <= cfg_timeout;
                        state_r     <= ARMED;
                    end else begin
                        timeout_err <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ramp_sequencer.md
Name: ramp_sequencer

Overview:
- Top-level controller for a bank of per-channel DAC ramp blocks.
- Sequences each acquisition run: arm, wait for trigger, ramp up, run, ramp down, done.
- Drives each ramp block's reset, enable and ramp-down request, and monitors the signed per-channel ramp-state codes each block reports.
- Sits between the PS configuration/command registers and the DAC ramp blocks; exposes status for readback.

Parameters:
- NUM_CH, 2, number of ramp channels controlled.
- TO_W, 32, width of the timeout counter and of cfg_timeout.

Ports:
- clk  in  1  system clock.
- aresetn  in  1  synchronous active-low reset, sampled on posedge clk.
- cfg_ch_mask  in  NUM_CH  channels taking part in the run; latched on accepted cmd_start.
- cfg_timeout  in  TO_W  max cycles allowed in RAMP_UP or RAMP_DOWN; 0 disables the timeout; latched on accepted cmd_start.
- cmd_start  in  1  single-cycle pulse: arm a run.
- cmd_stop  in  1  single-cycle pulse: abort or finish a run.
- trigger  in  1  external trigger, level; its rising edge is detected internally.
- ramp_state  in  16*NUM_CH  signed per-channel state codes; channel i occupies bits [16i+15:16i].
- ramper_resetn  out  1  active-low reset to all ramp blocks.
- enable_ramping  out  NUM_CH  per-channel ramp enable; equals the latched mask while a run is active.
- start_ramp_down  out  NUM_CH  per-channel ramp-down request, held as a level.
- busy  out  1  high in ARMED, RAMP_UP, RUNNING and RAMP_DOWN.
- done  out  1  one-cycle pulse on the DONE to IDLE transition.
- timeout_err  out  1  sticky; set on entry to FAULT.
- seq_state  out  3  current state encoding, for register readback.

Behaviour:
- All outputs are registered. Reset values: ramper_resetn=0, enable_ramping=0, start_ramp_down=0, busy=0, done=0, timeout_err=0, seq_state=IDLE. Internal registers: mask=0, timeout counter=0, stop_pending=0, trig_d=0.
- Trigger edge: trig_rise = trigger & ~trig_d, with trig_d registered every cycle.
- Channel status predicates: all_normal = for every masked channel, code == CODE_NORMAL (0). all_done = for every masked channel, code == CODE_DONE (4000). Unmasked channels are ignored. With an empty mask both predicates are true.
- IDLE:
  - ramper_resetn=0, all channel outputs 0.
  - cmd_start latches mask and timeout, then goes to ARMED.
- ARMED:
  - ramper_resetn stays 0.
  - cmd_stop goes to IDLE.
  - Otherwise trig_rise goes to RAMP_UP.
  - If cmd_stop and trig_rise occur in the same cycle, stop wins.
- RAMP_UP:
  - ramper_resetn=1, enable_ramping=mask. Timeout counter counts from 0.
  - all_normal goes to RUNNING.
  - A cmd_stop here sets stop_pending; the state does not change.
- RUNNING:
  - Counter is cleared.
  - cmd_stop or stop_pending goes to RAMP_DOWN and clears stop_pending.
- RAMP_DOWN:
  - start_ramp_down=mask, held until the state is left.
  - all_done goes to DONE.
  - Further cmd_stop pulses are ignored.
- DONE:
  - Lasts one cycle: done=1, ramper_resetn=0, start_ramp_down=0.
  - Next state is IDLE.
- Timeout:
  - In RAMP_UP and RAMP_DOWN, when cfg_timeout != 0 and the counter reaches cfg_timeout-1 without the exit predicate, go to FAULT.
  - The exit predicate has priority over timeout in the same cycle.
- FAULT:
  - ramper_resetn=0, all channel outputs 0, timeout_err=1.
  - cmd_start clears timeout_err, re-latches config and goes to ARMED.
  - cmd_stop goes to IDLE and leaves timeout_err set.
- cmd_start while busy is ignored.
- If cmd_start and cmd_stop arrive together in IDLE or FAULT, stop wins.
- Counter saturates at its maximum value and never wraps.
- Reset asserted mid-run:
  - All state returns to reset values on the next edge.
  - ramper_resetn drops the same cycle the register updates.
- Output latency: one cycle from the state-register update to the outputs.

Decomposition:
- Shared package ramp_pkg holds:
  - state localparams: IDLE=0, ARMED=1, RAMP_UP=2, RUNNING=3, RAMP_DOWN=4, DONE=5, FAULT=6;
  - ramp block codes: CODE_UP=2000, CODE_NORMAL=0, CODE_REQDOWN=-2000, CODE_DOWN=-4000, CODE_DONE=4000.
- The ramp block also uses ramp_pkg.
- One sub-module: ramp_state_monitor. It is combinational; it takes ramp_state and mask, and outputs all_normal and all_done.

Test Plan:
- Nominal run: mask=2'b11, timeout=0. Apply start, trigger edge, both codes to 0 after 10 cycles, stop, both codes to 4000 → states ARMED, RAMP_UP, RUNNING, RAMP_DOWN, DONE, IDLE; done high for exactly 1 cycle; start_ramp_down=2'b11 only while in RAMP_DOWN.
- Masked channel: mask=2'b01, ch1 code stuck at 2000 → RUNNING is reached once ch0=0; ch1 is never enabled and never requested to ramp down.
- Timeout: timeout=100, codes stuck at 2000 → FAULT after exactly 100 cycles in RAMP_UP; timeout_err=1; ramper_resetn=0. A following cmd_start clears timeout_err and gives ARMED.
- Early stop: cmd_stop 3 cycles into RAMP_UP → stays in RAMP_UP until all_normal, then RAMP_DOWN on the next cycle without another stop.
- Collisions: cmd_stop with trig_rise in ARMED gives IDLE. cmd_start in RUNNING is ignored. aresetn low in RAMP_DOWN forces all outputs to reset values.
